// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, fetch FSM encoding and address helpers.
// FETCH_TIMEOUT_EN adds the HALT state used by the fetch timeout.
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h01;
   localparam logic [5:0] OP_ORI   = 6'h02;
   localparam logic [5:0] OP_ANDI  = 6'h03;
   localparam logic [5:0] OP_LW    = 6'h04;
   localparam logic [5:0] OP_SW    = 6'h05;
   localparam logic [5:0] OP_BEQ   = 6'h06;
   localparam logic [5:0] OP_BGT   = 6'h07;
   localparam logic [5:0] OP_J     = 6'h08;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

`ifdef FETCH_TIMEOUT_EN
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StIssue = 2'd2,
      StHalt  = 2'd3
   } fetchStateT;
`else
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StIssue = 2'd2
   } fetchStateT;
`endif

   function automatic logic [31:0] wordAlign(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

   // Branch displacement: sign-extended 16-bit word offset turned into a byte offset.
   function automatic logic [31:0] branchOffset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master) and memory (slave).
interface instr_fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump beats a taken branch, which beats sequential (pc + 4).
module next_pc_calc
   import cpu_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   input  logic        jump,
   input  logic        branch_eq,
   input  logic        branch_gr,
   input  logic        alu_zero,
   input  logic        alu_gt,
   output logic [31:0] next_pc
);

   logic [31:0] seqPc;
   logic        branchTaken;
   logic        unusedOpcodeBits;

   assign unusedOpcodeBits = ^instr[31:26];

   always_comb begin
      seqPc       = pc + 32'd4;
      branchTaken = (branch_eq & alu_zero) | (branch_gr & alu_gt);
      if (jump) begin
         next_pc = {seqPc[31:28], instr[25:0], 2'b00};
      end else if (branchTaken) begin
         next_pc = seqPc + branchOffset(instr[15:0]);
      end else begin
         next_pc = seqPc;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches over a req/ack bus and presents one instruction at a time.
// Define FETCH_TIMEOUT_EN to add a bounded ack wait with a sticky fetch_err and HALT state.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst,
   instr_fetch_unit_if.master  imem,
   input  logic                stall,
   input  logic                jump,
   input  logic                branch_eq,
   input  logic                branch_gr,
   input  logic                alu_zero,
   input  logic                alu_gt,
   output logic [31:0]         instr,
   output logic [5:0]          opcode,
   output logic                instr_valid,
   output logic [31:0]         pc,
   output logic                fetch_err
);

   fetchStateT  state;
   logic [31:0] pcReg;
   logic [31:0] addrReg;
   logic [31:0] instrReg;
   logic        reqReg;
   logic        validReg;
   logic [31:0] nextPc;

   next_pc_calc u_next_pc_calc (
      .pc        (pcReg),
      .instr     (instrReg),
      .jump      (jump),
      .branch_eq (branch_eq),
      .branch_gr (branch_gr),
      .alu_zero  (alu_zero),
      .alu_gt    (alu_gt),
      .next_pc   (nextPc)
   );

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned    CntW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES);

   logic [CntW-1:0] waitCnt;
   logic [CntW-1:0] waitCntInc;
   logic            errReg;

   // waitCntInc is the number of FETCH cycles completed once this one ends.
   assign waitCntInc = waitCnt + CntW'(1);
   assign fetch_err  = errReg;
`else
   localparam int unsigned unusedTimeout = TIMEOUT_CYCLES;

   assign fetch_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= StIdle;
         pcReg    <= wordAlign(RESET_PC);
         addrReg  <= wordAlign(RESET_PC);
         instrReg <= 32'd0;
         reqReg   <= 1'b0;
         validReg <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         waitCnt  <= '0;
         errReg   <= 1'b0;
`endif
      end else begin
         unique case (state)
            StIdle: begin
               reqReg  <= 1'b1;
               addrReg <= pcReg;
               state   <= StFetch;
`ifdef FETCH_TIMEOUT_EN
               waitCnt <= '0;
`endif
            end
            StFetch: begin
               // An ack arriving on the expiring cycle still completes the fetch.
               if (imem.imem_ack) begin
                  instrReg <= imem.imem_rdata;
                  reqReg   <= 1'b0;
                  validReg <= 1'b1;
                  state    <= StIssue;
`ifdef FETCH_TIMEOUT_EN
               end else if (waitCntInc == CntLimit) begin
                  errReg   <= 1'b1;
                  reqReg   <= 1'b0;
                  state    <= StHalt;
               end else begin
                  waitCnt  <= waitCntInc;
`endif
               end
            end
            StIssue: begin
               if (!stall) begin
                  pcReg    <= wordAlign(nextPc);
                  addrReg  <= wordAlign(nextPc);
                  reqReg   <= 1'b1;
                  validReg <= 1'b0;
                  state    <= StFetch;
`ifdef FETCH_TIMEOUT_EN
                  waitCnt  <= '0;
`endif
               end
            end
`ifdef FETCH_TIMEOUT_EN
            StHalt: begin
               reqReg   <= 1'b0;
               validReg <= 1'b0;
            end
`endif
            default: begin
               reqReg   <= 1'b0;
               validReg <= 1'b0;
               state    <= StIdle;
            end
         endcase
      end
   end

   assign imem.imem_req  = reqReg;
   assign imem.imem_addr = addrReg;
   assign instr          = instrReg;
   assign opcode         = instrReg[31:26];
   assign instr_valid    = validReg;
   assign pc             = pcReg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a memory responder, a PC-level model checked every
// cycle, and hand-computed literal expectations for reset, branches, jumps, stall and reset.
module tb_instr_fetch_unit;

   localparam logic [31:0] ResetPc     = 32'h0000_0000;
   localparam logic [31:0] DefaultWord = 32'h0400_0005;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        jump = 1'b0;
   logic        branch_eq = 1'b0;
   logic        branch_gr = 1'b0;
   logic        alu_zero = 1'b0;
   logic        alu_gt = 1'b0;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic [31:0] pc;
   logic        fetch_err;

   instr_fetch_unit_if imemBus ();

   instr_fetch_unit #(
      .RESET_PC       (ResetPc),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem        (imemBus),
      .stall       (stall),
      .jump        (jump),
      .branch_eq   (branch_eq),
      .branch_gr   (branch_gr),
      .alu_zero    (alu_zero),
      .alu_gt      (alu_gt),
      .instr       (instr),
      .opcode      (opcode),
      .instr_valid (instr_valid),
      .pc          (pc),
      .fetch_err   (fetch_err)
   );

   always #5 clk = ~clk;

   int unsigned nChecks = 0;
   int unsigned nPass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Sparse instruction memory; unlisted words read as ADDI.
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return DefaultWord;
   endfunction

   // Where the next instruction must come from, straight from the ISA rules.
   function automatic logic [31:0] modelNext(input logic [31:0] p, input logic [31:0] w,
                                             input logic j, input logic beq, input logic bgt,
                                             input logic z, input logic gt);
      logic [31:0] seq;
      int          off;
      seq = p + 32'd4;
      if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
      if ((beq && z) || (bgt && gt)) begin
         off = int'($signed(w[15:0])) * 4;
         return seq + 32'(off);
      end
      return seq;
   endfunction

   // Memory responder: ack arrives ackDelay cycles after req rises.
   int unsigned ackDelay = 1;
   bit          forceAck = 1'b0;

   initial begin
      int unsigned waitCnt;
      waitCnt = 0;
      imemBus.imem_ack   = 1'b0;
      imemBus.imem_rdata = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (forceAck) begin
            imemBus.imem_ack   = 1'b1;
            imemBus.imem_rdata = 32'hDEAD_BEEF;
         end else if (imemBus.imem_req) begin
            if (waitCnt >= ackDelay) begin
               imemBus.imem_ack   = 1'b1;
               imemBus.imem_rdata = memWord(imemBus.imem_addr);
               waitCnt = 0;
            end else begin
               imemBus.imem_ack = 1'b0;
               waitCnt++;
            end
         end else begin
            imemBus.imem_ack = 1'b0;
            waitCnt = 0;
         end
      end
   end

   // Per-cycle compare against the PC-level model.
   initial begin
      logic [31:0] expPc;
      expPc = ResetPc;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            expPc = ResetPc;
         end else begin
            check("addr_align", {30'd0, imemBus.imem_addr[1:0]}, 32'd0);
            if (imemBus.imem_req) check("fetch_addr", imemBus.imem_addr, expPc);
            if (instr_valid) begin
               check("issue_pc", pc, expPc);
               check("issue_instr", instr, memWord(expPc));
               check("issue_opcode", 32'(opcode), 32'(memWord(expPc) >> 26));
               check("no_req_in_issue", 32'(imemBus.imem_req), 32'd0);
            end
`ifndef FETCH_TIMEOUT_EN
            check("fetch_err_tied", 32'(fetch_err), 32'd0);
`endif
            if (instr_valid && !stall)
               expPc = modelNext(expPc, memWord(expPc), jump, branch_eq, branch_gr,
                                 alu_zero, alu_gt);
         end
      end
   end

   task automatic waitPc(input logic [31:0] target, input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!(instr_valid && pc == target) && n < 80) begin
         @(negedge clk);
         n++;
      end
      check({name, "_reached"}, 32'(instr_valid && pc == target), 32'd1);
   endtask

   // ctl = {jump, branch_eq, branch_gr, alu_zero, alu_gt}, applied during the ISSUE cycle.
   task automatic issueWith(input logic [31:0] at, input logic [4:0] ctl,
                            input logic [31:0] expNext, input string name);
      waitPc(at, name);
      #1 {jump, branch_eq, branch_gr, alu_zero, alu_gt} = ctl;
      @(negedge clk);
      check({name, "_req"}, 32'(imemBus.imem_req), 32'd1);
      check({name, "_next"}, imemBus.imem_addr, expNext);
      #1 {jump, branch_eq, branch_gr, alu_zero, alu_gt} = 5'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] pcs [3];
      int          nValid;
      int          n;
      int          reqCycles;

      mem[32'h0000_0010] = 32'h1800_FFFE;
      mem[32'h0000_0014] = 32'h1800_FFF9;
      mem[32'h0000_0018] = 32'h23FF_FFFF;
      mem[32'h1000_0000] = 32'h2000_0040;
      mem[32'h1000_0118] = 32'hFC00_0000;

      repeat (3) @(negedge clk);
      check("rst_req", 32'(imemBus.imem_req), 32'd0);
      check("rst_addr", imemBus.imem_addr, ResetPc);
      check("rst_pc", pc, ResetPc);
      check("rst_instr", instr, 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_err", 32'(fetch_err), 32'd0);
      #1 rst = 1'b0;

      // Sequential stream: one issue every third cycle at 0, 4, 8.
      nValid = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (instr_valid) begin
            if (nValid < 3) pcs[nValid] = pc;
            if (nValid == 0) check("first_opcode", 32'(opcode), 32'h01);
            nValid++;
         end
      end
      check("valid_1_in_3", 32'(nValid), 32'd3);
      check("seq_pc0", pcs[0], 32'h0);
      check("seq_pc1", pcs[1], 32'h4);
      check("seq_pc2", pcs[2], 32'h8);

      // Slow memory: ack 5 cycles after req rises, so req is high for 6 sampled cycles.
      #1 ackDelay = 5;
      n = 0;
      reqCycles = 0;
      do begin
         @(negedge clk);
         if (imemBus.imem_req) reqCycles++;
         n++;
      end while (!instr_valid && n < 40);
      check("delay_req_cycles", 32'(reqCycles), 32'd6);
      check("delay_issue_pc", pc, 32'hC);
      check("delay_issue_instr", instr, DefaultWord);
      #1 ackDelay = 1;

      issueWith(32'h0000_0010, 5'b01010, 32'h0000_000C, "beq_taken");
      issueWith(32'h0000_0010, 5'b01000, 32'h0000_0014, "beq_not_taken");
      issueWith(32'h0000_0014, 5'b01010, 32'hFFFF_FFFC, "beq_backward");
      issueWith(32'hFFFF_FFFC, 5'b00000, 32'h0000_0000, "seq_wrap");
      issueWith(32'h0000_0018, 5'b10000, 32'h0FFF_FFFC, "jump_low");
      issueWith(32'h0FFF_FFFC, 5'b00000, 32'h1000_0000, "seq_carry");
      issueWith(32'h1000_0000, 5'b11010, 32'h1000_0100, "jump_beats_branch");
      issueWith(32'h1000_0100, 5'b00101, 32'h1000_0118, "bgt_taken");
      issueWith(32'h1000_0118, 5'b00110, 32'h1000_011C, "bgt_not_taken");
      check("unknown_opcode", 32'(opcode), 32'h3F);

      // Stall holds the issue slot; stray acks meanwhile must be ignored.
      waitPc(32'h1000_011C, "stall");
      #1;
      stall    = 1'b1;
      forceAck = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_valid", 32'(instr_valid), 32'd1);
         check("stall_pc", pc, 32'h1000_011C);
         check("stall_instr", instr, DefaultWord);
         check("stall_req", 32'(imemBus.imem_req), 32'd0);
      end
      #1;
      stall    = 1'b0;
      forceAck = 1'b0;
      @(negedge clk);
      check("unstall_req", 32'(imemBus.imem_req), 32'd1);
      check("unstall_addr", imemBus.imem_addr, 32'h1000_0120);

      // Asynchronous reset in the middle of a fetch.
      #1 rst = 1'b1;
      #1;
      check("async_rst_req", 32'(imemBus.imem_req), 32'd0);
      check("async_rst_pc", pc, ResetPc);
      check("async_rst_addr", imemBus.imem_addr, ResetPc);
      @(negedge clk);
      check("rst_hold_req", 32'(imemBus.imem_req), 32'd0);
      check("rst_hold_pc", pc, ResetPc);
      check("rst_hold_valid", 32'(instr_valid), 32'd0);
      #1 rst = 1'b0;
      waitPc(ResetPc, "post_reset");
      check("post_reset_instr", instr, DefaultWord);

`ifdef FETCH_TIMEOUT_EN
      // Ack on the 16th FETCH cycle wins over the expiring count.
      #1 ackDelay = 15;
      n = 0;
      reqCycles = 0;
      do begin
         @(negedge clk);
         if (imemBus.imem_req) reqCycles++;
         n++;
      end while (!instr_valid && !fetch_err && n < 60);
      check("late_ack_req_cycles", 32'(reqCycles), 32'd16);
      check("late_ack_valid", 32'(instr_valid), 32'd1);
      check("late_ack_no_err", 32'(fetch_err), 32'd0);

      // No ack at all: error after 16 FETCH cycles, then parked.
      #1 ackDelay = 1000;
      n = 0;
      reqCycles = 0;
      do begin
         @(negedge clk);
         if (imemBus.imem_req) reqCycles++;
         n++;
      end while (!fetch_err && n < 60);
      check("timeout_req_cycles", 32'(reqCycles), 32'd16);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("halt_err", 32'(fetch_err), 32'd1);
         check("halt_req", 32'(imemBus.imem_req), 32'd0);
         check("halt_valid", 32'(instr_valid), 32'd0);
      end
      #1 rst = 1'b1;
      #1 check("err_cleared", 32'(fetch_err), 32'd0);
      ackDelay = 1;
      @(negedge clk);
      #1 rst = 1'b0;
      waitPc(ResetPc, "after_halt");
`endif

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
